// File: rtl/mux8_scan_seq.sv
// ---------------------------------------------------------------------------
// mux8_scan_seq
//   Upstream sequencer for an external 8:1 select mux. A parallel word is
//   accepted over a valid/ready handshake and held on the mux data inputs.
//   The block then steps the select code through all eight positions and
//   waits a settle window after each step. It samples the mux output back and
//   presents that bit on a valid/ready serial output, so the mux and this
//   block together act as a PISO. Any sampled bit that differs from the held
//   input bit sets a sticky flag, which stays set until the next accept.
//
// Parameters
//   SETTLE_CYC   cycles from a select change to sampling y_i (1..15)
//   MSB_FIRST    0: select order 0->7, otherwise 7->0
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   din_i[7:0]     parallel word; din_i[k] drives mux input Ik
//   din_valid_i    din_i valid
//   din_ready_o    word can be accepted (decoded from IDLE)
//   i_o[7:0]       held word, wired to mux inputs I0..I7
//   s_o[2:0]       select code, wired to mux selects S2..S0
//   y_i            mux output fed back
//   dout_o         sampled bit
//   dout_valid_o   dout_o valid
//   dout_ready_i   consumer accepts dout_o
//   dout_last_o    qualifies the 8th bit of a word
//   mismatch_o     sticky: a sampled bit differed from the held input bit
// ---------------------------------------------------------------------------
module mux8_scan_seq #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output logic       din_ready_o,
    output logic [7:0] i_o,
    output logic [2:0] s_o,
    input  logic       y_i,
    output logic       dout_o,
    output logic       dout_valid_o,
    input  logic       dout_ready_i,
    output logic       dout_last_o,
    output logic       mismatch_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LD = SETTLE_CYC[3:0];
    localparam logic [2:0] S_FIRST   = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

    state_e     state_q;
    logic [7:0] i_q;
    logic [2:0] s_q;
    logic [2:0] s_d;
    logic [3:0] settle_cnt_q;
    logic [2:0] bit_idx_q;
    logic       dout_q;
    logic       dout_valid_q;
    logic       dout_last_q;
    logic       mismatch_q;

    // Next select position. The last bit returns to IDLE, so this never wraps
    // within a word.
    assign s_d = (MSB_FIRST != 0) ? (s_q - 3'd1) : (s_q + 3'd1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            s_q          <= '0;
            settle_cnt_q <= '0;
            bit_idx_q    <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din_valid_i) begin
                        i_q          <= din_i;
                        s_q          <= S_FIRST;
                        settle_cnt_q <= SETTLE_LD;
                        bit_idx_q    <= '0;
                        mismatch_q   <= 1'b0;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q - 4'd1;
                    // The select has been stable for SETTLE_CYC edges, so the
                    // mux output is settled. Sample it and compare it against
                    // the bit the mux should be passing.
                    if (settle_cnt_q == 4'd1) begin
                        dout_q       <= y_i;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= (bit_idx_q == 3'd7);
                        mismatch_q   <= mismatch_q | (y_i != i_q[s_q]);
                        state_q      <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Select and output stay frozen until the consumer takes
                    // the bit.
                    if (dout_ready_i) begin
                        dout_valid_q <= 1'b0;
                        dout_last_q  <= 1'b0;
                        if (dout_last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            s_q          <= s_d;
                            bit_idx_q    <= bit_idx_q + 3'd1;
                            settle_cnt_q <= SETTLE_LD;
                            state_q      <= ST_SETTLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign din_ready_o  = (state_q == ST_IDLE);
    assign i_o          = i_q;
    assign s_o          = s_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign dout_last_o  = dout_last_q;
    assign mismatch_o   = mismatch_q;

endmodule
